// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Purpose  : Multi-cycle fetch/issue controller for the RV32I core. Owns the
//             PC, fetches over a req/gnt/rvalid handshake, holds the word for
//             decode until exec_done, then advances or redirects. A misaligned
//             redirect target parks the block in a sticky fault state.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_hold,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc_out,
  input  logic        i_exec_done,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_retired_count,
  output logic        o_fault
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic [31:0] r_instr, w_instr_next;
  logic [31:0] r_count, w_count_next;

  // State, PC, held instruction and retire counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_instr <= NOP_WORD;
      r_count <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_instr <= w_instr_next;
      r_count <= w_count_next;
    end
  end

  // Next-state, datapath updates and state-decoded outputs.
  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_instr_next  = r_instr;
    w_count_next  = r_count;
    o_imem_req    = 1'b0;
    o_instr_valid = 1'b0;
    o_fault       = 1'b0;
    case (r_state)
      S_REQ: begin
        o_imem_req = !i_hold;
        // A grant only counts while the request is actually being driven.
        if (!i_hold && i_imem_gnt) begin
          if (i_imem_rvalid) begin
            w_instr_next = i_imem_rdata;
            w_state_next = S_ISSUE;
          end else begin
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (i_imem_rvalid) begin
          w_instr_next = i_imem_rdata;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_instr_valid = 1'b1;
        if (i_exec_done) begin
          w_count_next = r_count + 32'd1;
          if (i_redirect && (i_redirect_pc[1:0] != 2'b00)) begin
            // PC is left pointing at the faulting instruction.
            w_state_next = S_FAULT;
          end else if (i_redirect) begin
            w_pc_next    = i_redirect_pc;
            w_state_next = S_REQ;
          end else begin
            w_pc_next    = r_pc + 32'd4;
            w_state_next = S_REQ;
          end
        end
      end
      S_FAULT: begin
        o_fault = 1'b1;
      end
      default: begin
        w_state_next = S_REQ;
      end
    endcase
  end

  assign o_imem_addr     = r_pc;
  assign o_pc_out        = r_pc;
  assign o_instr         = r_instr;
  assign o_retired_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_sequencer
//  Purpose  : Self-checking bench for fetch_sequencer: a table of instruction
//             transactions plus hand-written fault and reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_hold, i_imem_gnt, i_imem_rvalid, i_exec_done, i_redirect;
  logic [31:0] i_imem_rdata, i_redirect_pc;
  logic        o_imem_req, o_instr_valid, o_fault;
  logic [31:0] o_imem_addr, o_instr, o_pc_out, o_retired_count;

  localparam logic [31:0] C_NOP  = 32'h0000_0013;
  localparam logic [31:0] C_JUNK = 32'hDEAD_BEEF;

  fetch_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_hold          (i_hold),
    .o_imem_req      (o_imem_req),
    .o_imem_addr     (o_imem_addr),
    .i_imem_gnt      (i_imem_gnt),
    .i_imem_rvalid   (i_imem_rvalid),
    .i_imem_rdata    (i_imem_rdata),
    .o_instr_valid   (o_instr_valid),
    .o_instr         (o_instr),
    .o_pc_out        (o_pc_out),
    .i_exec_done     (i_exec_done),
    .i_redirect      (i_redirect),
    .i_redirect_pc   (i_redirect_pc),
    .o_retired_count (o_retired_count),
    .o_fault         (o_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          hold_cyc;
    int          rv_lat;
    logic [31:0] rdata;
    int          ex_wait;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
    logic [31:0] exp_cnt;
    logic        exp_fault;
    int          exp_period;
  } vec_t;

  logic [63:0] sb[$];
  int n_pass  = 0;
  int n_total = 0;

  function automatic vec_t mkv(input int h, input int rv, input logic [31:0] d,
                               input int ew, input logic rd, input logic [31:0] rp,
                               input logic [31:0] ea, input logic [31:0] en,
                               input logic [31:0] ec, input logic ef, input int ep);
    vec_t v;
    v.hold_cyc = h;  v.rv_lat = rv; v.rdata = d;    v.ex_wait = ew;
    v.redir = rd;    v.rpc = rp;    v.exp_addr = ea; v.exp_next = en;
    v.exp_cnt = ec;  v.exp_fault = ef; v.exp_period = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one full fetch/issue/retire transaction starting in REQ.
  task automatic run_vec(input vec_t v, input int idx);
    int t0;
    logic [63:0] e;
    t0 = cyc;
    chk($sformatf("v%0d_addr", idx), o_imem_addr, v.exp_addr);
    for (int k = 0; k < v.hold_cyc; k++) begin
      i_hold = 1'b1; i_imem_gnt = 1'b1;
      #1 chk($sformatf("v%0d_req_held", idx), o_imem_req, 1'b0);
      tick();
      chk($sformatf("v%0d_addr_held", idx), o_imem_addr, v.exp_addr);
      chk($sformatf("v%0d_valid_held", idx), o_instr_valid, 1'b0);
    end
    i_hold = 1'b0; i_imem_gnt = 1'b1;
    #1 chk($sformatf("v%0d_req", idx), o_imem_req, 1'b1);
    if (v.rv_lat == 0) begin
      i_imem_rvalid = 1'b1; i_imem_rdata = v.rdata;
      sb.push_back({v.exp_addr, v.rdata});
    end
    tick();
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = C_JUNK;
    if (v.rv_lat > 0) begin
      for (int k = 1; k < v.rv_lat; k++) begin
        i_hold = 1'b1; i_exec_done = 1'b1;
        #1 chk($sformatf("v%0d_wait_req", idx), o_imem_req, 1'b0);
        chk($sformatf("v%0d_wait_valid", idx), o_instr_valid, 1'b0);
        tick();
      end
      i_hold = 1'b0; i_exec_done = 1'b0;
      i_imem_rvalid = 1'b1; i_imem_rdata = v.rdata;
      sb.push_back({v.exp_addr, v.rdata});
      tick();
      i_imem_rvalid = 1'b0; i_imem_rdata = C_JUNK;
    end
    chk($sformatf("v%0d_valid_rise", idx), o_instr_valid, 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("v%0d_pc_out", idx), o_pc_out, e[63:32]);
      chk($sformatf("v%0d_instr", idx), o_instr, e[31:0]);
    end else begin
      chk($sformatf("v%0d_sb_underflow", idx), sb.size(), 1);
    end
    for (int k = 0; k < v.ex_wait; k++) begin
      tick();
      chk($sformatf("v%0d_valid_hold", idx), o_instr_valid, 1'b1);
    end
    i_exec_done = 1'b1; i_redirect = v.redir; i_redirect_pc = v.rpc;
    tick();
    i_exec_done = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'd0;
    chk($sformatf("v%0d_count", idx), o_retired_count, v.exp_cnt);
    chk($sformatf("v%0d_next_addr", idx), o_imem_addr, v.exp_next);
    chk($sformatf("v%0d_fault", idx), o_fault, v.exp_fault);
    chk($sformatf("v%0d_instr_kept", idx), o_instr, v.rdata);
    chk($sformatf("v%0d_period", idx), cyc - t0, v.exp_period);
  endtask

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    //           hold rv data          ew rd rpc           addr          next          cnt f per
    tbl[0] = mkv(0, 1, 32'h0000_00A0, 0, 0, 32'h0,        32'h0,        32'h4,        1, 0, 3);
    tbl[1] = mkv(0, 1, 32'h0000_00A1, 0, 0, 32'h0,        32'h4,        32'h8,        2, 0, 3);
    tbl[2] = mkv(0, 1, 32'h0000_00A2, 0, 0, 32'h0,        32'h8,        32'hC,        3, 0, 3);
    tbl[3] = mkv(0, 0, 32'h0073_02B3, 0, 0, 32'h0,        32'hC,        32'h10,       4, 0, 2);
    tbl[4] = mkv(5, 1, 32'h1111_2222, 0, 1, 32'h100,      32'h10,       32'h100,      5, 0, 8);
    tbl[5] = mkv(0, 4, 32'h3333_4444, 2, 1, 32'hFFFF_FFFC, 32'h100,     32'hFFFF_FFFC, 6, 0, 8);
    tbl[6] = mkv(0, 1, 32'h5555_6666, 0, 0, 32'h0,        32'hFFFF_FFFC, 32'h0,       7, 0, 3);
    tbl[7] = mkv(0, 1, 32'h7777_8888, 0, 1, 32'h102,      32'h0,        32'h0,        8, 1, 3);

    rst_n = 1'b0; i_hold = 1'b0; i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0;
    i_imem_rdata = C_JUNK; i_exec_done = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'd0;
    tick(); tick();
    chk("rst_req", o_imem_req, 1'b1);
    chk("rst_addr", o_imem_addr, 32'h0);
    chk("rst_valid", o_instr_valid, 1'b0);
    chk("rst_instr", o_instr, C_NOP);
    chk("rst_pc_out", o_pc_out, 32'h0);
    chk("rst_count", o_retired_count, 32'd0);
    chk("rst_fault", o_fault, 1'b0);
    i_hold = 1'b1;
    #1 chk("rst_req_hold", o_imem_req, 1'b0);
    i_hold = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

    // Fault is terminal: every input is ignored.
    for (int k = 0; k < 4; k++) begin
      i_hold = k[0]; i_imem_gnt = 1'b1; i_imem_rvalid = 1'b1; i_exec_done = 1'b1;
      i_redirect = 1'b1; i_redirect_pc = 32'h200;
      #1 chk("flt_req", o_imem_req, 1'b0);
      chk("flt_valid", o_instr_valid, 1'b0);
      chk("flt_fault", o_fault, 1'b1);
      tick();
      chk("flt_count", o_retired_count, 32'd8);
      chk("flt_addr", o_imem_addr, 32'h0);
    end
    i_hold = 1'b0; i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_exec_done = 1'b0;
    i_redirect = 1'b0; i_redirect_pc = 32'd0;

    // Asynchronous reset clears the fault without a clock edge.
    rst_n = 1'b0;
    #2;
    chk("arst_fault", o_fault, 1'b0);
    chk("arst_count", o_retired_count, 32'd0);
    chk("arst_instr", o_instr, C_NOP);
    chk("arst_req", o_imem_req, 1'b1);
    tick();
    rst_n = 1'b1;

    run_vec(mkv(0, 0, 32'h0ABC_DEF0, 0, 0, 32'h0, 32'h0, 32'h4, 1, 0, 2), 8);

    // Reset while a fetch is outstanding, then a stale rvalid without grant.
    i_imem_gnt = 1'b1;
    tick();
    i_imem_gnt = 1'b0;
    chk("mid_wait_req", o_imem_req, 1'b0);
    chk("mid_wait_addr", o_imem_addr, 32'h4);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_addr", o_imem_addr, 32'h0);
    chk("mid_rst_instr", o_instr, C_NOP);
    chk("mid_rst_req", o_imem_req, 1'b1);
    tick();
    rst_n = 1'b1;
    i_imem_rvalid = 1'b1; i_imem_rdata = 32'hBAD0_BAD0;
    tick();
    i_imem_rvalid = 1'b0; i_imem_rdata = C_JUNK;
    chk("stale_valid", o_instr_valid, 1'b0);
    chk("stale_instr", o_instr, C_NOP);
    chk("stale_req", o_imem_req, 1'b1);
    chk("stale_addr", o_imem_addr, 32'h0);
    chk("sb_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle fetch/issue controller for the RV32I core. Owns the program counter, fetches each instruction word from instruction memory over a request/grant/valid handshake, and holds it stable for the instruction decoder and datapath until the datapath signals completion. On completion it advances the PC sequentially or takes a branch/jump redirect, and it faults permanently on a misaligned redirect target.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded at reset; must be word aligned (bits [1:0] = 0)
- NOP_WORD, 32'h0000_0013, value of `instr` while no instruction is held (addi x0,x0,0)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- hold  in  1  stall request; suppresses new fetch requests
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address (= current PC)
- imem_gnt  in  1  memory accepted the request this cycle
- imem_rvalid  in  1  `imem_rdata` valid this cycle
- imem_rdata  in  32  fetched instruction word
- instr_valid  out  1  `instr` and `pc_out` are valid for decode/execute
- instr  out  32  held instruction word, to instruction decoder
- pc_out  out  32  PC of the held instruction
- exec_done  in  1  datapath finished the held instruction
- redirect  in  1  qualifies `exec_done`: take `redirect_pc`
- redirect_pc  in  32  branch/jump target
- retired_count  out  32  instructions completed since reset
- fault  out  1  sticky misaligned-redirect fault

## Operation
- States: REQ, WAIT, ISSUE, FAULT. Reset state: REQ.
- REQ: `imem_req` = !hold, `imem_addr` = pc.
  - hold=1: stay; `imem_gnt` ignored.
  - gnt & !rvalid -> WAIT.
  - gnt & rvalid (same cycle) -> capture `imem_rdata` into `instr`, go to ISSUE.
- WAIT: `imem_req` = 0. On rvalid: capture `imem_rdata` into `instr`, go to ISSUE. `hold` has no effect here.
- ISSUE: `instr_valid` = 1, `pc_out` = pc. On exec_done:
  - `retired_count` += 1, wrapping mod 2^32.
  - If redirect=1 and redirect_pc[1:0] != 0: go to FAULT; pc unchanged; count still increments.
  - Else if redirect=1: pc <= redirect_pc, go to REQ.
  - Else: pc <= pc + 4, wrapping mod 2^32 (32'hFFFF_FFFC -> 0), go to REQ.
- FAULT: terminal until reset. `fault` = 1, `imem_req` = 0, `instr_valid` = 0. All inputs ignored.
- Ignored inputs:
  - `exec_done` and `redirect` outside ISSUE.
  - `imem_rvalid` outside REQ/WAIT.
  - `imem_gnt` outside REQ.
- `instr` holds its last captured word until the next capture.
- `instr` = NOP_WORD only from reset until the first capture.
- Reset, any time (including mid-fetch with an outstanding request): all state is cleared immediately. A late `imem_rvalid` after reset is discarded, since the block is then in REQ.

## Timing
- Reset values:
  - `imem_req` = 1 (combinational; 0 if hold), `imem_addr` = RESET_PC
  - `instr_valid` = 0, `instr` = NOP_WORD, `pc_out` = RESET_PC
  - `retired_count` = 0, `fault` = 0
- `imem_req`, `imem_addr`, `instr_valid`, `pc_out` and `fault` are decoded from registered state. `imem_req` additionally gates with `hold`.
- `instr_valid` rises the cycle after the rvalid capture edge.
- Minimum instruction period:
  - 2 cycles: gnt+rvalid in the REQ cycle, exec_done in the first ISSUE cycle.
  - 3 cycles: rvalid one cycle after gnt.
- A new pc is visible on `imem_addr` the cycle after the exec_done edge.
- `retired_count` updates on the same edge as pc.

## Test plan
- Sequential fetch: reset, gnt and rvalid each 1 cycle after req, exec_done on the first ISSUE cycle -> addresses 0x0, 0x4, 0x8; 3 cycles per instruction; `retired_count` = 3 after the third exec_done.
- Combined handshake: gnt+rvalid same cycle, rdata = 32'h0073_02B3 -> `instr` = 32'h0073_02B3 and `instr_valid` = 1 next cycle; period 2 cycles.
- Redirect and wrap:
  - exec_done with redirect, redirect_pc = 32'h0000_0100 -> next `imem_addr` = 0x100.
  - With pc = 32'hFFFF_FFFC and no redirect -> next `imem_addr` = 0x0.
- Hold and stalls:
  - hold=1 for 5 cycles in REQ -> `imem_req` = 0 throughout, no state change.
  - rvalid delayed 4 cycles in WAIT -> `instr_valid` stays 0 until the capture.
- Misaligned redirect: redirect_pc = 32'h0000_0102 -> `fault` = 1 next cycle, `imem_req` = 0 thereafter, `retired_count` incremented; only rst_n clears it.
- Reset mid-fetch: assert rst_n=0 in WAIT, then release -> `imem_addr` = RESET_PC, `instr` = NOP_WORD; a stale rvalid in the first REQ cycle without gnt is ignored.
